comb_stack_arbiter: RTL and testbench

//  Shares one single-port stack RAM between NREQ recursive-combination controllers.

---
 rtl/comb_stack_pkg.sv | 11 +
 rtl/comb_rr_arbiter.sv | 42 ++++
 rtl/comb_stack_arbiter.sv | 153 +++++++++++++++
 tb/tb_comb_stack_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/comb_stack_pkg.sv
// Shared op encodings for the comb_stack_arbiter block.
package comb_stack_pkg;

   typedef enum logic [1:0] {
      OP_TOP  = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_RSVD = 2'b11
   } op_t;

endpackage

// File: rtl/comb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first candidate at or after the rr pointer.
module comb_rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          cand,
   output logic [NREQ-1:0]          gnt,
   output logic [$clog2(NREQ)-1:0]  gnt_id,
   output logic                     gnt_any
);

   localparam int IW = $clog2(NREQ);

   logic [IW-1:0] ptr_q, ptr_d;

   always_comb begin
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      ptr_d   = ptr_q;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!gnt_any && cand[idx]) begin
            gnt_any  = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = IW'(idx);
         end
      end
      if (gnt_any)
         ptr_d = (int'(gnt_id) == NREQ-1) ? '0 : gnt_id + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/comb_stack_arbiter.sv
// Shared stack RAM with per-requester regions and round-robin access.
// Optional STACK_HWM_EN adds per-requester high-water-mark outputs.
module comb_stack_arbiter
   import comb_stack_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int NREQ   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [2*NREQ-1:0]        op,
   input  logic [NREQ*DATA_W-1:0]   wdata,
   input  logic [NREQ-1:0]          clr,
   output logic [NREQ-1:0]          gnt,
   output logic                     rvalid,
   output logic [$clog2(NREQ)-1:0]  rid,
   output logic [DATA_W-1:0]        rdata,
   output logic                     err,
   output logic [NREQ-1:0]          full,
   output logic [NREQ-1:0]          empty
`ifdef STACK_HWM_EN
  ,output logic [NREQ*($clog2(DEPTH)+1)-1:0] hwm
`endif
);

   localparam int IW  = $clog2(NREQ);
   localparam int DW  = $clog2(DEPTH);
   localparam int SPW = DW + 1;
   localparam int AW  = IW + DW;

   logic [NREQ-1:0][SPW-1:0] sp_q, sp_d;
   logic [DATA_W-1:0]        mem [NREQ*DEPTH];
   logic                     rvalid_q, rvalid_d, err_q, err_d;
   logic [IW-1:0]            rid_q, rid_d;
   logic [DATA_W-1:0]        rdata_q, rdata_d;
   logic [NREQ-1:0]          cand;
   logic [IW-1:0]            gnt_id;
   logic                     gnt_any;
   logic                     we;
   logic [AW-1:0]            waddr, raddr;
   logic [SPW-1:0]           sp_k;
   op_t                      cur_op;

   // clr masks its own requester; reset holds off every grant
   assign cand = req & ~clr & {NREQ{~rst}};

   comb_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .cand    (cand),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_any (gnt_any)
   );

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         full[i]  = (sp_q[i] == SPW'(DEPTH));
         empty[i] = (sp_q[i] == '0);
      end
   end

   always_comb begin
      sp_d     = sp_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      rid_d    = rid_q;
      rdata_d  = rdata_q;
      we       = 1'b0;
      cur_op   = op_t'(op[2*gnt_id +: 2]);
      sp_k     = sp_q[gnt_id];
      // region base is gnt_id*DEPTH, so the index is a plain concatenation
      waddr    = {gnt_id, sp_k[DW-1:0]};
      raddr    = {gnt_id, DW'(sp_k - 1'b1)};
      for (int i = 0; i < NREQ; i++)
         if (clr[i]) sp_d[i] = '0;
      if (gnt_any) begin
         case (cur_op)
            OP_PUSH: begin
               if (full[gnt_id]) begin
                  err_d = 1'b1;
                  rid_d = gnt_id;
               end else begin
                  we           = 1'b1;
                  sp_d[gnt_id] = sp_k + 1'b1;
               end
            end
            OP_TOP, OP_POP: begin
               rid_d = gnt_id;
               if (empty[gnt_id]) begin
                  err_d = 1'b1;
               end else begin
                  rvalid_d = 1'b1;
                  rdata_d  = mem[raddr];
                  if (cur_op == OP_POP) sp_d[gnt_id] = sp_k - 1'b1;
               end
            end
            default: begin
               err_d = 1'b1;
               rid_d = gnt_id;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q     <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rid_q    <= '0;
         rdata_q  <= '0;
      end else begin
         sp_q     <= sp_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rid_q    <= rid_d;
         rdata_q  <= rdata_d;
      end
   end

   // RAM contents survive reset
   always_ff @(posedge clk) begin
      if (!rst && we) mem[waddr] <= wdata[gnt_id*DATA_W +: DATA_W];
   end

   assign rvalid = rvalid_q;
   assign err    = err_q;
   assign rid    = rid_q;
   assign rdata  = rdata_q;

`ifdef STACK_HWM_EN
   logic [NREQ-1:0][SPW-1:0] hwm_q, hwm_d;

   always_comb begin
      hwm_d = hwm_q;
      for (int i = 0; i < NREQ; i++) begin
         if (clr[i])                 hwm_d[i] = '0;
         else if (sp_q[i] > hwm_q[i]) hwm_d[i] = sp_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) hwm_q <= '0;
      else     hwm_q <= hwm_d;
   end

   assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_comb_stack_arbiter.sv
// Scoreboard bench for comb_stack_arbiter: directed ops, queued expected read/err responses.
module tb_comb_stack_arbiter;
   import comb_stack_pkg::*;

   typedef struct packed {
      logic       rv;
      logic       er;
      logic       id;
      logic [7:0] rd;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [3:0]  op;
   logic [15:0] wdata;
   logic [1:0]  clr;
   logic [1:0]  gnt;
   logic        rvalid;
   logic        rid;
   logic [7:0]  rdata;
   logic        err;
   logic [1:0]  full;
   logic [1:0]  empty;
`ifdef STACK_HWM_EN
   logic [9:0]  hwm;
`endif

   int    n_cmp = 0;
   int    n_bad = 0;
   resp_t exp_q[$];

   always #5 clk = ~clk;

   comb_stack_arbiter #(.DATA_W(8), .DEPTH(16), .NREQ(2)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .op     (op),
      .wdata  (wdata),
      .clr    (clr),
      .gnt    (gnt),
      .rvalid (rvalid),
      .rid    (rid),
      .rdata  (rdata),
      .err    (err),
      .full   (full),
      .empty  (empty)
`ifdef STACK_HWM_EN
     ,.hwm    (hwm)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic expect_resp(input logic rv, input logic er, input logic id, input logic [7:0] rd);
      resp_t r;
      r.rv = rv; r.er = er; r.id = id; r.rd = rd;
      exp_q.push_back(r);
   endtask

   // called at a negedge; drives one cycle of inputs and checks the combinational grant
   task automatic issue(input string nm, input logic [1:0] r, input op_t o1, input op_t o0,
                        input logic [15:0] wd, input logic [1:0] c, input logic [1:0] eg);
      req = r; op = {o1, o0}; wdata = wd; clr = c;
      #1 chk(nm, 32'(gnt), 32'(eg));
      @(negedge clk);
   endtask

   task automatic idle();
      req = '0; op = '0; clr = '0;
      @(negedge clk);
   endtask

   // monitor: every read/err pulse must match the head of the expected queue
   initial begin
      resp_t got, want;
      forever begin
         @(negedge clk);
         if (!rst && (rvalid || err)) begin
            got.rv = rvalid; got.er = err; got.id = rid; got.rd = rdata;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_resp: got %0h want none", got);
            end else begin
               want = exp_q.pop_front();
               chk("resp", 32'(got), 32'(want));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; req = '0; op = '0; wdata = '0; clr = '0;
      repeat (2) @(negedge clk);
      req = 2'b01; op = {OP_TOP, OP_PUSH};
      #1 chk("gnt_in_rst", 32'(gnt), 0);
      @(negedge clk);
      rst = 1'b0; req = '0; op = '0;
      #1;
      chk("rst_empty", 32'(empty), 32'h3);
      chk("rst_full", 32'(full), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_rid", 32'(rid), 0);
      chk("rst_rdata", 32'(rdata), 0);
      @(negedge clk);

      // basic LIFO on requester 0
      issue("gnt_push11", 2'b01, OP_TOP, OP_PUSH, 16'h0011, 2'b00, 2'b01);
      issue("gnt_push22", 2'b01, OP_TOP, OP_PUSH, 16'h0022, 2'b00, 2'b01);
      issue("gnt_push33", 2'b01, OP_TOP, OP_PUSH, 16'h0033, 2'b00, 2'b01);
      chk("empty_after_push", 32'(empty), 32'h2);
      expect_resp(1'b1, 1'b0, 1'b0, 8'h33);
      issue("gnt_pop1", 2'b01, OP_TOP, OP_POP, 16'h0, 2'b00, 2'b01);
      expect_resp(1'b1, 1'b0, 1'b0, 8'h22);
      issue("gnt_pop2", 2'b01, OP_TOP, OP_POP, 16'h0, 2'b00, 2'b01);
      expect_resp(1'b1, 1'b0, 1'b0, 8'h11);
      issue("gnt_pop3", 2'b01, OP_TOP, OP_POP, 16'h0, 2'b00, 2'b01);
      chk("empty_after_pops", 32'(empty), 32'h3);

      // both push every cycle; pointer sits at 1 after the last grant to 0
      for (int i = 0; i < 4; i++)
         issue("gnt_alt", 2'b11, OP_PUSH, OP_PUSH, {8'(8'hB0 + i), 8'(8'hA0 + i)}, 2'b00,
               (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("empty_after_alt", 32'(empty), 0);
      expect_resp(1'b1, 1'b0, 1'b0, 8'hA3);
      issue("gnt_pop_a3", 2'b01, OP_TOP, OP_POP, 16'h0, 2'b00, 2'b01);
      expect_resp(1'b1, 1'b0, 1'b0, 8'hA1);
      issue("gnt_pop_a1", 2'b01, OP_TOP, OP_POP, 16'h0, 2'b00, 2'b01);
      chk("empty0_after_alt_pops", 32'(empty), 32'h1);

      // fill requester 1 (holds B0,B2) up to DEPTH, then overflow
      issue("gnt_push5a", 2'b01, OP_TOP, OP_PUSH, 16'h005A, 2'b00, 2'b01);
      for (int i = 0; i < 14; i++)
         issue("gnt_fill1", 2'b10, OP_PUSH, OP_TOP, {8'(8'hC0 + i), 8'h00}, 2'b00, 2'b10);
      chk("full_at_depth", 32'(full), 32'h2);
      expect_resp(1'b0, 1'b1, 1'b1, 8'hA1);
      issue("gnt_push_full", 2'b10, OP_PUSH, OP_TOP, 16'hEE00, 2'b00, 2'b10);
      chk("full_after_ovf", 32'(full), 32'h2);

      // TOP leaves sp0 at 1, so one POP empties it
      expect_resp(1'b1, 1'b0, 1'b0, 8'h5A);
      issue("gnt_top", 2'b01, OP_TOP, OP_TOP, 16'h0, 2'b00, 2'b01);
      expect_resp(1'b1, 1'b0, 1'b0, 8'h5A);
      issue("gnt_pop_5a", 2'b01, OP_TOP, OP_POP, 16'h0, 2'b00, 2'b01);
      chk("empty0_after_top_pop", 32'(empty), 32'h1);
      expect_resp(1'b1, 1'b0, 1'b1, 8'hCD);
      issue("gnt_pop_cd", 2'b10, OP_POP, OP_TOP, 16'h0, 2'b00, 2'b10);

      // underflow and reserved op
      expect_resp(1'b0, 1'b1, 1'b0, 8'hCD);
      issue("gnt_pop_empty", 2'b01, OP_TOP, OP_POP, 16'h0, 2'b00, 2'b01);
      expect_resp(1'b0, 1'b1, 1'b0, 8'hCD);
      issue("gnt_rsvd", 2'b01, OP_TOP, OP_RSVD, 16'h0, 2'b00, 2'b01);
      idle();
      chk("err_is_pulse", 32'(err), 0);
      chk("empty0_after_ovf", 32'(empty), 32'h1);

      // clr[1] masks req1's POP; req0's PUSH proceeds the same cycle
      issue("gnt_clr1", 2'b11, OP_POP, OP_PUSH, 16'h0077, 2'b10, 2'b01);
      chk("empty_after_clr", 32'(empty), 32'h2);
      issue("gnt_clr_only", 2'b10, OP_POP, OP_TOP, 16'h0, 2'b10, 2'b00);

      // reset during a POP drops the read
      rst = 1'b1;
      issue("gnt_pop_in_rst", 2'b01, OP_TOP, OP_POP, 16'h0, 2'b00, 2'b00);
      chk("rvalid_after_rst", 32'(rvalid), 0);
      chk("err_after_rst", 32'(err), 0);
      rst = 1'b0;
      idle();
      chk("empty_after_rst", 32'(empty), 32'h3);

`ifdef STACK_HWM_EN
      for (int i = 0; i < 5; i++)
         issue("gnt_hwm_push", 2'b01, OP_TOP, OP_PUSH, {8'h00, 8'(8'h10 + i)}, 2'b00, 2'b01);
      for (int i = 0; i < 3; i++) begin
         expect_resp(1'b1, 1'b0, 1'b0, 8'(8'h14 - i));
         issue("gnt_hwm_pop", 2'b01, OP_TOP, OP_POP, 16'h0, 2'b00, 2'b01);
      end
      issue("gnt_hwm_push2", 2'b01, OP_TOP, OP_PUSH, 16'h0099, 2'b00, 2'b01);
      idle();
      chk("hwm0", 32'(hwm[4:0]), 5);
      issue("gnt_hwm_clr", 2'b00, OP_TOP, OP_TOP, 16'h0, 2'b01, 2'b00);
      idle();
      chk("hwm0_clr", 32'(hwm[4:0]), 0);
`endif

      idle();
      idle();
      chk("scoreboard_drain", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
